// File: rtl/raster_pkg.sv
// Shared rasterizer types and framebuffer constants.
// Also holds the pixel-to-word address helper used by the framebuffer writer.
package raster_pkg;

    localparam int FB_WORD_PIXELS   = 4;
    localparam int FB_WORDS_PER_ROW = 160;
    localparam int FB_ADDR_BITS     = 17;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
    } coord_2d_t;

    typedef struct packed {
        logic [9:0]  x;
        logic [8:0]  y;
        logic [15:0] z;
    } coord_3d_t;

    typedef struct packed {
        coord_3d_t  v0;
        coord_3d_t  v1;
        coord_3d_t  v2;
        logic [3:0] color;
    } polygon_t;

    typedef struct packed {
        logic [FB_ADDR_BITS-1:0] addr;
        logic [15:0]             data;
        logic [3:0]              en;
    } fb_word_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ACCUM,
        WR_FLUSH
    } wr_state_e;

    // y*160 + x/4 without a multiplier: 160 = 128 + 32
    function automatic logic [FB_ADDR_BITS-1:0] fb_word_addr(input coord_2d_t p);
        logic [FB_ADDR_BITS-1:0] y_ext;
        y_ext = FB_ADDR_BITS'(p.y);
        return (y_ext << 7) + (y_ext << 5) + FB_ADDR_BITS'(p.x[9:2]);
    endfunction

endpackage

// File: rtl/fb_word_fifo.sv
// Synchronous FIFO for packed framebuffer words.
// Head is read straight from registered storage and forced to zero when empty.
module fb_word_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot a full push needs
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/tile_fb_writer.sv
// Packs rasterizer pixel beats into 4-pixel nibble-enabled words and queues them
// for a request/grant framebuffer write port, with a tile flush/drain handshake.
module tile_fb_writer
    import raster_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FB_WIDTH   = 640,
    parameter int FB_HEIGHT  = 480
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    vld_in,
    output logic                    rdy_out,
    input  logic [3:0]              color_in,
    input  coord_2d_t               pixel_in,
    input  logic                    flush,
    output logic                    flush_done,
    output logic                    mem_req,
    input  logic                    mem_gnt,
    output logic [FB_ADDR_BITS-1:0] mem_addr,
    output logic [15:0]             mem_wdata,
    output logic [3:0]              mem_nib_en,
    output logic                    err_oob
);

    localparam int         CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int         NIB_W = 16 / FB_WORD_PIXELS;
    localparam logic [9:0] X_LIM = 10'(FB_WIDTH);
    localparam logic [8:0] Y_LIM = 9'(FB_HEIGHT);

    wr_state_e               state_q, state_d;
    logic [FB_ADDR_BITS-1:0] acc_addr_q, acc_addr_d;
    logic [15:0]             acc_data_q, acc_data_d;
    logic [3:0]              acc_en_q, acc_en_d;
    logic                    rdy_out_q, rdy_out_d;
    logic                    flush_done_q, flush_done_d;
    logic                    err_oob_q, err_oob_d;

    logic                    beat, in_range, good;
    logic [FB_ADDR_BITS-1:0] b_addr;
    logic [1:0]              b_nib;
    logic                    push, pop;
    fb_word_t                push_word, head;
    logic                    fifo_full, fifo_empty;
    logic [CW-1:0]           fifo_count, count_nxt;

    assign beat     = vld_in && rdy_out_q;
    assign in_range = (pixel_in.x < X_LIM) && (pixel_in.y < Y_LIM);
    assign good     = beat && in_range;
    assign b_addr   = fb_word_addr(pixel_in);
    assign b_nib    = pixel_in.x[1:0];
    assign mem_req  = !fifo_empty;
    assign pop      = mem_req && mem_gnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= WR_IDLE;
            acc_addr_q   <= '0;
            acc_data_q   <= '0;
            acc_en_q     <= '0;
            rdy_out_q    <= 1'b0;
            flush_done_q <= 1'b0;
            err_oob_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_addr_q   <= acc_addr_d;
            acc_data_q   <= acc_data_d;
            acc_en_q     <= acc_en_d;
            rdy_out_q    <= rdy_out_d;
            flush_done_q <= flush_done_d;
            err_oob_q    <= err_oob_d;
        end
    end

    // Accumulator merge and FIFO push; at most one push per cycle.
    always_comb begin
        acc_addr_d = acc_addr_q;
        acc_data_d = acc_data_q;
        acc_en_d   = acc_en_q;
        push       = 1'b0;
        push_word  = {acc_addr_q, acc_data_q, acc_en_q};
        if (good) begin
            if (acc_en_q != 4'h0 && acc_addr_q != b_addr) begin
                push       = 1'b1;
                acc_data_d = '0;
                acc_en_d   = '0;
            end
            acc_addr_d                        = b_addr;
            acc_data_d[b_nib*NIB_W +: NIB_W]  = color_in;
            acc_en_d[b_nib]                   = 1'b1;
            if (acc_en_d == 4'hF) begin
                push       = 1'b1;
                push_word  = {acc_addr_d, acc_data_d, acc_en_d};
                acc_data_d = '0;
                acc_en_d   = '0;
            end
        end
        // a partial word blocked by a full FIFO is retried from FLUSH
        if ((state_q == WR_FLUSH || flush) && !push && acc_en_d != 4'h0 && !fifo_full) begin
            push       = 1'b1;
            push_word  = {acc_addr_d, acc_data_d, acc_en_d};
            acc_data_d = '0;
            acc_en_d   = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WR_FLUSH: if (acc_en_q == 4'h0 && fifo_empty) state_d = WR_IDLE;
            default:  state_d = flush ? WR_FLUSH : ((acc_en_d != 4'h0) ? WR_ACCUM : WR_IDLE);
        endcase
    end

    always_comb begin
        count_nxt = fifo_count;
        if (push && !pop)      count_nxt = fifo_count + CW'(1);
        else if (pop && !push) count_nxt = fifo_count - CW'(1);
    end

    always_comb begin
        rdy_out_d    = (state_d != WR_FLUSH) && (count_nxt != CW'(FIFO_DEPTH));
        flush_done_d = (state_q == WR_FLUSH) && (state_d == WR_IDLE);
        err_oob_d    = err_oob_q || (beat && !in_range);
    end

    fb_word_fifo #(
        .WIDTH ($bits(fb_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_word),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rdy_out    = rdy_out_q;
    assign flush_done = flush_done_q;
    assign err_oob    = err_oob_q;
    assign mem_addr   = head.addr;
    assign mem_wdata  = head.data;
    assign mem_nib_en = head.en;

endmodule

// File: tb/tb_tile_fb_writer.sv
// Randomized and directed bench for tile_fb_writer against a pixel-grouping model.
// Writes seen on the memory port are collected and compared in order with the model.
module tb_tile_fb_writer;
    import raster_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0, rst_n = 1'b0, vld_in = 1'b0, flush = 1'b0, mem_gnt = 1'b0;
    logic [3:0] color_in = '0;
    coord_2d_t  pixel_in = '0;
    logic       rdy_out, flush_done, mem_req, err_oob;
    logic [16:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [3:0]  mem_nib_en;

    int checks = 0, errors = 0;
    fb_word_t got_q[$], exp_q[$];
    int fd_cnt = 0;
    bit gnt_rand = 1'b0;
    logic gnt_fix = 1'b0;

    // model: currently open word, expected writes, flush and error expectations
    bit         m_open = 1'b0;
    int         m_addr = 0;
    logic [15:0] m_data = '0;
    logic [3:0]  m_en = '0;
    bit         m_err = 1'b0;
    int         m_fd = 0;

    tile_fb_writer #(.FIFO_DEPTH(DEPTH), .FB_WIDTH(640), .FB_HEIGHT(480)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vld_in     (vld_in),
        .rdy_out    (rdy_out),
        .color_in   (color_in),
        .pixel_in   (pixel_in),
        .flush      (flush),
        .flush_done (flush_done),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_nib_en (mem_nib_en),
        .err_oob    (err_oob)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        mem_gnt = gnt_rand ? ($urandom_range(0, 1) == 1) : gnt_fix;
    end

    always @(negedge clk) begin
        fb_word_t w;
        w = {mem_addr, mem_wdata, mem_nib_en};
        if (rst_n && mem_req && mem_gnt) got_q.push_back(w);
        if (rst_n && flush_done) fd_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic model_close();
        fb_word_t w;
        if (m_open) begin
            w = {17'(m_addr), m_data, m_en};
            exp_q.push_back(w);
        end
        m_open = 1'b0;
    endtask

    task automatic model_beat(input int x, input int y, input logic [3:0] c);
        int a;
        if (x >= 640 || y >= 480) begin m_err = 1'b1; return; end
        a = y * FB_WORDS_PER_ROW + x / FB_WORD_PIXELS;
        if (m_open && m_addr != a) model_close();
        if (!m_open) begin m_open = 1'b1; m_addr = a; m_data = '0; m_en = '0; end
        m_data[(x % 4) * 4 +: 4] = c;
        m_en[x % 4] = 1'b1;
        if (m_en == 4'hF) model_close();
    endtask

    task automatic model_flush();
        model_close();
        m_fd++;
    endtask

    // Presents a beat, waits until it is taken, optionally flushing in that cycle.
    task automatic send_beat(input int x, input int y, input logic [3:0] c, input bit fl);
        int n = 0;
        vld_in = 1'b1; pixel_in.x = 10'(x); pixel_in.y = 9'(y); color_in = c;
        while (!rdy_out && n < 300) begin cyc(1); n++; end
        checks++;
        if (!rdy_out) begin
            errors++;
            $display("FAIL beat_accept x=%0d y=%0d: rdy_out=%0b required 1", x, y, rdy_out);
            vld_in = 1'b0;
            return;
        end
        flush = fl;
        model_beat(x, y, c);
        if (fl) model_flush();
        cyc(1);
        vld_in = 1'b0; flush = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        int n = 0;
        while ((got_q.size() < exp_q.size() || fd_cnt < m_fd || mem_req) && n < 2000) begin
            cyc(1); n++;
        end
        cyc(2);
        ok = (n < 2000);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rdy_out, flush_done, mem_req, err_oob, mem_addr, mem_wdata, mem_nib_en} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b fd=%b req=%b err=%b addr=%h data=%h en=%h required all 0",
                     rdy_out, flush_done, mem_req, err_oob, mem_addr, mem_wdata, mem_nib_en);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1);
        checks++;
        if (rdy_out !== 1'b1) begin errors++; $display("FAIL reset_release_rdy: rdy_out=%b required 1", rdy_out); end
    endtask

    task automatic test_full_word();
        int base = exp_q.size();
        bit ok;
        fb_word_t want;
        gnt_fix = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vld_in = 1'b1; pixel_in.x = 10'(i); pixel_in.y = 9'd0; color_in = 4'(i + 1);
            model_beat(i, 0, 4'(i + 1));
            @(negedge clk);
            checks++;
            if (rdy_out !== 1'b1 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL full_word_beat%0d: rdy=%b req=%b required rdy=1 req=0", i, rdy_out, mem_req);
            end
            @(posedge clk); #1;
        end
        vld_in = 1'b0;
        @(negedge clk);
        want = {17'd0, 16'h4321, 4'hF};
        checks++;
        if (mem_req !== 1'b1 || {mem_addr, mem_wdata, mem_nib_en} !== want) begin
            errors++;
            $display("FAIL full_word_req: req=%b word=%h required req=1 word=%h",
                     mem_req, {mem_addr, mem_wdata, mem_nib_en}, want);
        end
        @(posedge clk); #1;
        wait_drain(ok);
        checks++;
        if (!ok || got_q.size() != base + 1 || got_q[base] !== exp_q[base]) begin
            errors++;
            $display("FAIL full_word_write: got %0d writes (first %h) required %0d (%h)",
                     got_q.size() - base, (got_q.size() > base) ? got_q[base] : '0, 1, exp_q[base]);
        end
    endtask

    task automatic test_partial_flush();
        int base = exp_q.size();
        int fd0 = fd_cnt;
        int n = 0;
        fb_word_t w0, w1;
        gnt_fix = 1'b1;
        send_beat(5, 2, 4'd7, 1'b0);
        send_beat(9, 2, 4'd3, 1'b0);
        flush = 1'b1; model_flush();
        cyc(1);
        flush = 1'b0;
        while (n < 50) begin
            @(negedge clk);
            if (flush_done) break;
            checks++;
            if (rdy_out !== 1'b0) begin errors++; $display("FAIL flush_rdy_low: rdy_out=%b required 0", rdy_out); end
            @(posedge clk); #1;
            n++;
        end
        w0 = {17'd321, 16'h0070, 4'b0010};
        w1 = {17'd322, 16'h0030, 4'b0010};
        checks++;
        if (n >= 50) begin errors++; $display("FAIL flush_done_timeout: flush_done=%b required 1", flush_done); end
        checks++;
        if (got_q.size() != base + 2 || got_q[base] !== w0 || got_q[base + 1] !== w1) begin
            errors++;
            $display("FAIL partial_writes: got %0d writes required 2 (%h, %h)", got_q.size() - base, w0, w1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (flush_done !== 1'b0 || rdy_out !== 1'b1 || fd_cnt != fd0 + 1) begin
            errors++;
            $display("FAIL flush_single_pulse: fd=%b rdy=%b pulses=%0d required fd=0 rdy=1 pulses=1",
                     flush_done, rdy_out, fd_cnt - fd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overwrite();
        int base = exp_q.size();
        bit ok;
        fb_word_t want;
        gnt_fix = 1'b1;
        send_beat(2, 0, 4'd5, 1'b0);
        send_beat(2, 0, 4'd9, 1'b0);
        flush = 1'b1; model_flush();
        cyc(1);
        flush = 1'b0;
        wait_drain(ok);
        want = {17'd0, 16'h0900, 4'b0100};
        checks++;
        if (!ok || got_q.size() != base + 1 || got_q[base] !== want) begin
            errors++;
            $display("FAIL overwrite: got %0d writes (first %h) required 1 (%h)",
                     got_q.size() - base, (got_q.size() > base) ? got_q[base] : '0, want);
        end
    endtask

    task automatic test_backpressure();
        int base = exp_q.size();
        int fd0;
        bit ok;
        logic [3:0] col [20];
        for (int i = 0; i < 20; i++) col[i] = 4'($urandom_range(0, 15));
        gnt_fix = 1'b0;
        for (int i = 0; i < 16; i++) send_beat(i, 10, col[i], 1'b0);
        checks++;
        if (rdy_out !== 1'b0) begin errors++; $display("FAIL bp_full_rdy: rdy_out=%b required 0", rdy_out); end
        vld_in = 1'b1; pixel_in.x = 10'd16; pixel_in.y = 9'd10; color_in = col[16];
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (rdy_out !== 1'b0 || mem_req !== 1'b1 || {mem_addr, mem_wdata, mem_nib_en} !== exp_q[base]) begin
                errors++;
                $display("FAIL bp_stall_stable: rdy=%b req=%b word=%h required rdy=0 req=1 word=%h",
                         rdy_out, mem_req, {mem_addr, mem_wdata, mem_nib_en}, exp_q[base]);
            end
            @(posedge clk); #1;
        end
        gnt_fix = 1'b1;
        for (int i = 16; i < 20; i++) send_beat(i, 10, col[i], 1'b0);
        wait_drain(ok);
        checks++;
        if (!ok || got_q.size() != exp_q.size() || exp_q.size() != base + 5) begin
            errors++;
            $display("FAIL bp_count: got %0d writes required %0d", got_q.size() - base, 5);
        end
        for (int i = base; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL bp_write[%0d]: got %h required %h", i - base, got_q[i], exp_q[i]);
            end
        end
        // partial word pushed out by a new address fills the FIFO, then flush must wait for space
        base = exp_q.size();
        fd0 = fd_cnt;
        gnt_fix = 1'b0;
        for (int i = 0; i < 14; i++) send_beat(i, 11, col[i], 1'b0);
        send_beat(20, 11, col[19], 1'b0);
        flush = 1'b1; model_flush();
        cyc(1);
        flush = 1'b0;
        cyc(4);
        checks++;
        if (rdy_out !== 1'b0 || mem_req !== 1'b1 || fd_cnt != fd0) begin
            errors++;
            $display("FAIL flush_full_hold: rdy=%b req=%b pulses=%0d required rdy=0 req=1 pulses=0",
                     rdy_out, mem_req, fd_cnt - fd0);
        end
        gnt_fix = 1'b1;
        wait_drain(ok);
        checks++;
        if (!ok || got_q.size() != exp_q.size() || exp_q.size() != base + 5 || fd_cnt != fd0 + 1) begin
            errors++;
            $display("FAIL flush_full_count: got %0d writes %0d pulses required 5 writes 1 pulse",
                     got_q.size() - base, fd_cnt - fd0);
        end
        for (int i = base; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL flush_full_write[%0d]: got %h required %h", i - base, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_oob();
        int base = exp_q.size();
        bit ok;
        gnt_fix = 1'b1;
        checks++;
        if (err_oob !== 1'b0) begin errors++; $display("FAIL oob_initial: err_oob=%b required 0", err_oob); end
        send_beat(640, 0, 4'd1, 1'b0);
        send_beat(0, 480, 4'd2, 1'b0);
        cyc(1);
        checks++;
        if (err_oob !== 1'b1) begin errors++; $display("FAIL oob_sticky: err_oob=%b required 1", err_oob); end
        flush = 1'b1; model_flush();
        cyc(1);
        flush = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok || got_q.size() != base) begin
            errors++; $display("FAIL oob_no_write: got %0d writes required 0", got_q.size() - base);
        end
        for (int i = 4; i < 8; i++) send_beat(i, 1, 4'($urandom_range(0, 15)), 1'b0);
        wait_drain(ok);
        checks++;
        if (!ok || got_q.size() != base + 1 || got_q[base] !== exp_q[base]) begin
            errors++;
            $display("FAIL oob_then_valid: got %0d writes required 1 (%h)", got_q.size() - base, exp_q[base]);
        end
    endtask

    task automatic test_random();
        int base = exp_q.size();
        int cur_x = 0;
        int n;
        bit ok;
        gnt_rand = 1'b1;
        for (int it = 0; it < 400; it++) begin
            int r = $urandom_range(0, 99);
            if (r < 5) begin
                n = 0;
                while (!rdy_out && n < 300) begin cyc(1); n++; end
                flush = 1'b1; model_flush();
                cyc(1);
                if ($urandom_range(0, 1) == 1) cyc(1);
                flush = 1'b0;
            end else if (r < 8) begin
                if ($urandom_range(0, 1) == 1) send_beat(640 + $urandom_range(0, 383), $urandom_range(0, 479), 4'd1, 1'b0);
                else send_beat($urandom_range(0, 639), 480 + $urandom_range(0, 31), 4'd2, 1'b0);
            end else begin
                cur_x = ($urandom_range(0, 9) < 7) ? (cur_x + 1) % 32 : $urandom_range(0, 31);
                send_beat(cur_x, $urandom_range(0, 2), 4'($urandom_range(0, 15)), $urandom_range(0, 19) == 0);
            end
            if ($urandom_range(0, 3) == 0) cyc(1);
        end
        gnt_rand = 1'b0;
        gnt_fix = 1'b1;
        n = 0;
        while (!rdy_out && n < 300) begin cyc(1); n++; end
        flush = 1'b1; model_flush();
        cyc(1);
        flush = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok || got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_count: got %0d writes required %0d", got_q.size() - base, exp_q.size() - base);
        end
        for (int i = base; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rand_write[%0d]: got %h required %h", i - base, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (fd_cnt != m_fd || err_oob !== m_err) begin
            errors++;
            $display("FAIL rand_flush_err: pulses=%0d err=%b required pulses=%0d err=%b", fd_cnt, err_oob, m_fd, m_err);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        gnt_fix = 1'b0;
        for (int i = 0; i < 9; i++) send_beat(i, 3, 4'($urandom_range(0, 15)), 1'b0);
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_queued: mem_req=%b required 1", mem_req); end
        rst_n = 1'b0;
        cyc(1);
        @(negedge clk);
        checks++;
        if ({rdy_out, flush_done, mem_req, err_oob, mem_addr, mem_wdata, mem_nib_en} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: rdy=%b fd=%b req=%b err=%b addr=%h data=%h en=%h required all 0",
                     rdy_out, flush_done, mem_req, err_oob, mem_addr, mem_wdata, mem_nib_en);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete(); got_q.delete();
        m_open = 1'b0; m_err = 1'b0;
        gnt_fix = 1'b1;
        cyc(20);
        checks++;
        if (got_q.size() != 0 || mem_req !== 1'b0 || rdy_out !== 1'b1 || err_oob !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_stale: writes=%0d req=%b rdy=%b err=%b required 0 0 1 0",
                     got_q.size(), mem_req, rdy_out, err_oob);
        end
        for (int i = 0; i < 4; i++) send_beat(i, 5, 4'($urandom_range(0, 15)), 1'b0);
        wait_drain(ok);
        checks++;
        if (!ok || got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL mid_after_reset: got %0d writes required 1 (%h)", got_q.size(), exp_q[0]);
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_partial_flush();
        test_overwrite();
        test_backpressure();
        test_oob();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
